// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL lock controller: FSM state encoding
// and extraction of one field from the packed loop-filter profile table.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_LOCKED    = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  // Widest profile table the helper accepts; callers zero-extend into it.
  localparam int unsigned MAX_TBL_W = 4096;

  // Returns the field at bit lsb of profile idx, right-justified in 32 bits.
  function automatic logic [31:0] prof_field(input logic [MAX_TBL_W-1:0] tbl,
                                             input int unsigned idx,
                                             input int unsigned prof_w,
                                             input int unsigned lsb);
    return 32'(tbl >> (idx * prof_w + lsb));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL lock acquisition controller: resets the PLL, steps through loop-filter
// profiles until lock holds for STABLE_CYCLES, and re-acquires after loss.
module pll_lock_ctrl #(
  parameter int unsigned NUM_PROFILES  = 4,
  parameter int unsigned ICP_W         = 6,
  parameter int unsigned RES_W         = 3,
  parameter int unsigned CAP_W         = 2,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic                                         clkin,
  input  logic                                         reset_n,
  input  logic                                         enable,
  input  logic [NUM_PROFILES*(ICP_W+RES_W+CAP_W)-1:0]  profiles,
  input  logic                                         lock,
  output logic                                         pll_reset,
  output logic [ICP_W-1:0]                             icpsel,
  output logic [RES_W-1:0]                             lpfres,
  output logic [CAP_W-1:0]                             lpfcap,
  output logic                                         ready,
  output logic                                         fail,
  output logic [((NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1)-1:0] profile_idx,
  output logic [7:0]                                   relock_count
);

  import pll_ctrl_pkg::*;

  localparam int unsigned PROF_W    = ICP_W + RES_W + CAP_W;
  localparam int unsigned IDX_W     = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1;
  localparam int unsigned CNT_MAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > RST_CYCLES) ? CNT_MAX_A : RST_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  logic             w_lock_s;
  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [IDX_W-1:0] r_idx, w_idx_nx;
  logic [7:0]       r_relock, w_relock_nx;
  logic             w_load;
  logic             w_adv;
  logic             r_pll_reset, r_ready, r_fail;
  logic [ICP_W-1:0] r_icp, w_sel_icp, w_p0_icp;
  logic [RES_W-1:0] r_res, w_sel_res, w_p0_res;
  logic [CAP_W-1:0] r_cap, w_sel_cap, w_p0_cap;

  sync_2ff u_sync (
    .clk   (clkin),
    .rst_n (reset_n),
    .d     (lock),
    .q     (w_lock_s)
  );

  // Profile fields are packed {icp, res, cap} with cap in the LSBs.
  assign w_sel_icp = ICP_W'(prof_field(MAX_TBL_W'(profiles), 32'(r_idx), PROF_W, CAP_W + RES_W));
  assign w_sel_res = RES_W'(prof_field(MAX_TBL_W'(profiles), 32'(r_idx), PROF_W, CAP_W));
  assign w_sel_cap = CAP_W'(prof_field(MAX_TBL_W'(profiles), 32'(r_idx), PROF_W, 0));
  assign w_p0_icp  = ICP_W'(prof_field(MAX_TBL_W'(profiles), 0, PROF_W, CAP_W + RES_W));
  assign w_p0_res  = RES_W'(prof_field(MAX_TBL_W'(profiles), 0, PROF_W, CAP_W));
  assign w_p0_cap  = CAP_W'(prof_field(MAX_TBL_W'(profiles), 0, PROF_W, 0));

  // Next-state logic; one counter serves reset length, lock timeout and stability.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_idx_nx    = r_idx;
    w_relock_nx = r_relock;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    if (!enable) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_RESET;
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
        end
        ST_RESET: begin
          w_load = (r_cnt == CNT_W'(1));
          if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
            w_state_nx = ST_WAIT_LOCK;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_state_nx = ST_STABLE;
            w_cnt_nx   = '0;
          end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            w_adv = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          if (!w_lock_s) begin
            w_adv = 1'b1;
          end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            w_state_nx = ST_LOCKED;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (!w_lock_s) begin
            w_state_nx = ST_RESET;
            w_cnt_nx   = '0;
            if (r_relock != 8'hFF) w_relock_nx = r_relock + 8'd1;
          end
        end
        ST_FAIL:  w_state_nx = ST_FAIL;
        default:  w_state_nx = ST_IDLE;
      endcase
      if (w_adv) begin
        w_cnt_nx = '0;
        if (r_idx == IDX_W'(NUM_PROFILES - 1)) begin
          w_state_nx = ST_FAIL;
        end else begin
          w_state_nx = ST_RESET;
          w_idx_nx   = r_idx + IDX_W'(1);
        end
      end
    end
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_relock    <= '0;
      r_pll_reset <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_icp       <= w_p0_icp;
      r_res       <= w_p0_res;
      r_cap       <= w_p0_cap;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_idx       <= w_idx_nx;
      r_relock    <= w_relock_nx;
      r_pll_reset <= (w_state_nx inside {ST_IDLE, ST_RESET, ST_FAIL});
      r_ready     <= (w_state_nx == ST_LOCKED);
      r_fail      <= (w_state_nx == ST_FAIL);
      if (w_load) begin
        r_icp <= w_sel_icp;
        r_res <= w_sel_res;
        r_cap <= w_sel_cap;
      end
    end
  end

  assign pll_reset    = r_pll_reset;
  assign ready        = r_ready;
  assign fail         = r_fail;
  assign icpsel       = r_icp;
  assign lpfres       = r_res;
  assign lpfcap       = r_cap;
  assign profile_idx  = r_idx;
  assign relock_count = r_relock;

endmodule
